rx78_cart_loader: RTL and testbench
===================================

RX78_CART_LOADER -- requirements
Module: rx78_cart_loader

Interface
REQ-001 SHALL have parameter CART_INDEX, default 8'h01, the ioctl_index value that selects a cartridge download.
REQ-002 SHALL have parameter ADDR_W, default 15, the cartridge address width (CART_MAX = 2**ADDR_W bytes).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the write-buffer entries (power of two, at least 2).
REQ-004 SHALL have port clk_sys, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ioctl_download, input, 1 bit: download in progress.
REQ-007 SHALL have port ioctl_index, input, 8 bits: download target index.
REQ-008 SHALL have port ioctl_wr, input, 1 bit: single-cycle byte strobe.
REQ-009 SHALL have port ioctl_addr, input, 25 bits: byte offset within the file.
REQ-010 SHALL have port ioctl_dout, input, 8 bits: byte data.
REQ-011 SHALL have port mem_we, output, 1 bit: write request to cartridge RAM.
REQ-012 SHALL have port mem_addr, output, ADDR_W bits: write address.
REQ-013 SHALL have port mem_data, output, 8 bits: write data.
REQ-014 SHALL have port mem_ready, input, 1 bit: RAM accepts the request this cycle.
REQ-015 SHALL have port hold_reset, output, 1 bit: holds the console in reset while loading.
REQ-016 SHALL have port cart_valid, output, 1 bit: a complete image is resident.
REQ-017 SHALL have port cart_size, output, ADDR_W+1 bits: loaded length in bytes.
REQ-018 SHALL have port checksum, output, 16 bits: sum of accepted bytes.
REQ-019 SHALL have port err_oversize, output, 1 bit: a byte was dropped because its address was at or above CART_MAX.
REQ-020 SHALL have port err_overrun, output, 1 bit: a byte was dropped because the FIFO was full.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, DRAIN and DONE.
REQ-022 SHALL go from IDLE or DONE to LOAD on a cycle where ioctl_download=1, ioctl_index=CART_INDEX and the registered previous ioctl_download=0 (rising edge).
REQ-023 SHALL, on entering LOAD, clear cart_valid, cart_size, checksum, both error flags and the FIFO in the same edge.
REQ-024 SHALL ignore downloads with any other index in every state; outputs SHALL stay unchanged.
REQ-025 SHALL, in LOAD, honour ioctl_wr only while ioctl_download=1 in the same cycle.
REQ-026 SHALL, for an honoured byte with ioctl_addr < CART_MAX and FIFO not full, push {addr[ADDR_W-1:0], data} into the FIFO.
REQ-027 SHALL, for each pushed byte, add data to checksum modulo 2**16 and update cart_size to max(cart_size, addr+1).
REQ-028 SHALL drop an honoured byte with ioctl_addr >= CART_MAX, set err_oversize, and leave checksum and cart_size unchanged.
REQ-029 SHALL, when the FIFO is full, drop the byte and set err_overrun; fullness is evaluated on the registered count, so a pop in the same cycle does not free space.
REQ-030 SHALL drive mem_we=1 whenever the FIFO is non-empty, with mem_addr and mem_data taken from the FIFO head.
REQ-031 SHALL pop the head only on a cycle where mem_we=1 and mem_ready=1; mem_addr and mem_data SHALL hold stable until then.
REQ-032 SHALL give a minimum latency of 1 cycle: a byte pushed at edge N appears on mem_we after edge N.
REQ-033 SHALL go from LOAD to DRAIN on the cycle ioctl_download=0.
REQ-034 SHALL go from DRAIN to DONE on the cycle the FIFO count is 0.
REQ-035 SHALL set cart_valid=1 in DONE only if err_oversize=0 and err_overrun=0; DONE is still entered when either flag is set.
REQ-036 SHALL assert hold_reset=1 in LOAD and DRAIN and 0 in IDLE and DONE.
REQ-037 SHALL, on a new matching rising edge in DONE, restart per REQ-023 regardless of prior contents.
REQ-038 SHALL treat a matching ioctl_download that is already high when reset is released as not started; a rising edge is required.

Reset
REQ-039 SHALL, while reset_n=0, asynchronously force state IDLE, empty the FIFO, and drive mem_we=0, hold_reset=0, cart_valid=0, cart_size=0, checksum=0, err_oversize=0, err_overrun=0 and mem_addr/mem_data=0.
REQ-040 SHALL, on reset asserted mid-LOAD or mid-DRAIN, discard pending FIFO entries without issuing further mem_we.

Verification
REQ-041 SHALL be verified by: index 1, 4 bytes 11,22,33,44 at addr 0-3, mem_ready=1 -> four writes in address order, cart_size=4, checksum=16'h00AA, cart_valid=1, hold_reset falls after the last write.
REQ-042 SHALL be verified by: byte at addr 32768 during an index-1 load -> no write, err_oversize=1, cart_valid=0 in DONE.
REQ-043 SHALL be verified by: mem_ready=0 for 10 cycles while 6 strobes arrive 1 cycle apart -> 4 writes buffered, err_overrun=1, the first write holds address and data stable until mem_ready rises.
REQ-044 SHALL be verified by: index-2 download with strobes -> no mem_we, hold_reset=0, all outputs unchanged.
REQ-045 SHALL be verified by: reset_n pulsed low with 3 bytes in the FIFO -> mem_we=0 immediately, state IDLE, all outputs 0.
REQ-046 SHALL be verified by: 256 bytes of FF to addr 0-255 -> checksum=16'hFF00 (256 x FF), cart_size=256.

Source files
------------

// File: rtl/rx78_cart_loader.sv
// rx78_cart_loader: turns an ioctl file download into cartridge RAM writes
// through a small write FIFO, and tracks size, checksum and error status.
module rx78_cart_loader #(
    parameter logic [7:0] CART_INDEX = 8'h01,
    parameter int         ADDR_W     = 15,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ready,
    output logic              hold_reset,
    output logic              cart_valid,
    output logic [ADDR_W:0]   cart_size,
    output logic [15:0]       checksum,
    output logic              err_oversize,
    output logic              err_overrun
);

    localparam int             PTR_W      = $clog2(FIFO_DEPTH);
    localparam int             ENTRY_W    = ADDR_W + 8;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t state;
    state_t state_next;

    logic               prev_download;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    logic            index_match;
    logic            start;
    logic            honoured;
    logic            in_range;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [ADDR_W:0] end_addr;

    // A load starts only on a rising edge of a matching download, and only
    // when no load is already running.
    assign index_match = (ioctl_index == CART_INDEX);
    assign start       = ((state == IDLE) || (state == DONE)) && ioctl_download
                         && index_match && !prev_download;
    assign honoured    = (state == LOAD) && ioctl_download && ioctl_wr && index_match;
    assign in_range    = ((ioctl_addr >> ADDR_W) == 25'd0);

    // Fullness uses the registered count, so a same-cycle pop never makes room.
    assign fifo_full   = (count == FULL_COUNT);
    assign fifo_empty  = (count == '0);
    assign push        = honoured && in_range && !fifo_full;
    assign pop         = !fifo_empty && mem_ready;
    assign end_addr    = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W + 1)'(1);

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a fresh matching download always restarts the load.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (!ioctl_download) state_next = DRAIN;
                DRAIN:   if (fifo_empty)      state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    // Outputs: console held in reset while loading, RAM port fed from FIFO head.
    always_comb begin
        hold_reset = (state == LOAD) || (state == DRAIN);
        cart_valid = (state == DONE) && !err_oversize && !err_overrun;
        mem_we     = !fifo_empty;
        mem_addr   = '0;
        mem_data   = '0;
        if (!fifo_empty) begin
            {mem_addr, mem_data} = fifo_mem[rd_ptr];
        end
    end

    // FIFO bookkeeping, size/checksum accumulation and sticky error flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_download <= 1'b1;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            cart_size     <= '0;
            checksum      <= '0;
            err_oversize  <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            prev_download <= ioctl_download;
            if (start) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                count        <= '0;
                cart_size    <= '0;
                checksum     <= '0;
                err_oversize <= 1'b0;
                err_overrun  <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                    checksum <= checksum + {8'h00, ioctl_dout};
                    if (end_addr > cart_size) begin
                        cart_size <= end_addr;
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + (PTR_W + 1)'(1);
                    2'b01:   count <= count - (PTR_W + 1)'(1);
                    default: count <= count;
                endcase
                if (honoured && !in_range) begin
                    err_oversize <= 1'b1;
                end
                if (honoured && in_range && fifo_full) begin
                    err_overrun <= 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents are only visible through the count, so no reset.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
        end
    end

endmodule

// File: tb/tb_rx78_cart_loader.sv
// tb_rx78_cart_loader: vector table, directed corner cases and random traffic
// for rx78_cart_loader, all compared against a queue-based reference model.
module tb_rx78_cart_loader;

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [7:0]  data;
        logic        hold;
        logic        valid;
        logic [15:0] size;
        logic [15:0] sum;
        logic        ovs;
        logic        ovr;
    } outs_t;

    typedef struct {
        logic        dl;
        logic [7:0]  idx;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        ready;
        outs_t       exp;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl      = 1'b0;
    logic [7:0]  idx     = 8'h00;
    logic        wr      = 1'b0;
    logic [24:0] addr    = '0;
    logic [7:0]  dout    = '0;
    logic        ready   = 1'b0;

    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;
    logic        hold_reset;
    logic        cart_valid;
    logic [15:0] cart_size;
    logic [15:0] checksum;
    logic        err_oversize;
    logic        err_overrun;

    int checks = 0;
    int passed = 0;

    // Reference model: a load phase, a queue of outstanding writes and totals.
    int          m_phase;
    bit          m_prev;
    logic [22:0] m_q[$];
    int          m_size;
    logic [15:0] m_sum;
    bit          m_ovs;
    bit          m_ovr;

    rx78_cart_loader dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ioctl_download(dl),
        .ioctl_index(idx),
        .ioctl_wr(wr),
        .ioctl_addr(addr),
        .ioctl_dout(dout),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_ready(ready),
        .hold_reset(hold_reset),
        .cart_valid(cart_valid),
        .cart_size(cart_size),
        .checksum(checksum),
        .err_oversize(err_oversize),
        .err_overrun(err_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outs_t dutOuts();
        outs_t o;
        o.we    = mem_we;
        o.addr  = mem_addr;
        o.data  = mem_data;
        o.hold  = hold_reset;
        o.valid = cart_valid;
        o.size  = cart_size;
        o.sum   = checksum;
        o.ovs   = err_oversize;
        o.ovr   = err_overrun;
        return o;
    endfunction

    function automatic outs_t modelOuts();
        outs_t o;
        o.we           = (m_q.size() > 0);
        {o.addr, o.data} = (m_q.size() > 0) ? m_q[0] : 23'd0;
        o.hold         = (m_phase == 1) || (m_phase == 2);
        o.valid        = (m_phase == 3) && !m_ovs && !m_ovr;
        o.size         = 16'(m_size);
        o.sum          = m_sum;
        o.ovs          = m_ovs;
        o.ovr          = m_ovr;
        return o;
    endfunction

    task automatic modelReset();
        m_phase = 0;
        m_prev  = 1'b1;
        m_q.delete();
        m_size  = 0;
        m_sum   = '0;
        m_ovs   = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs about to be sampled.
    task automatic modelEdge();
        int occ = m_q.size();
        bit st  = ((m_phase == 0) || (m_phase == 3)) && dl && (idx == 8'h01) && !m_prev;
        if (st) begin
            m_q.delete();
            m_size  = 0;
            m_sum   = '0;
            m_ovs   = 1'b0;
            m_ovr   = 1'b0;
            m_phase = 1;
        end else begin
            if (occ > 0 && ready) void'(m_q.pop_front());
            if (m_phase == 1 && dl && wr && idx == 8'h01) begin
                if (addr >= 25'd32768) m_ovs = 1'b1;
                else if (occ >= 4) m_ovr = 1'b1;
                else begin
                    m_q.push_back({addr[14:0], dout});
                    m_sum = m_sum + {8'h00, dout};
                    if (int'(addr) + 1 > m_size) m_size = int'(addr) + 1;
                end
            end
            if (m_phase == 1 && !dl) m_phase = 2;
            else if (m_phase == 2 && occ == 0) m_phase = 3;
        end
        m_prev = dl;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic d, input logic [7:0] i, input logic w,
                                 input logic [24:0] a, input logic [7:0] v, input logic r);
        dl    = d;
        idx   = i;
        wr    = w;
        addr  = a;
        dout  = v;
        ready = r;
        modelEdge();
        @(posedge clk_sys);
        #1;
        checkOutput("model", 64'(dutOuts()), 64'(modelOuts()));
    endtask

    // Lets the current load run out, bounded, then checks the console is released.
    task automatic drainOut(input string name);
        for (int k = 0; k < 40 && hold_reset; k++) applyStimulus(1'b0, 8'h01, 1'b0, '0, '0, 1'b1);
        checkOutput(name, 64'(hold_reset), 64'(0));
    endtask

    vec_t        vecs[8];
    logic [22:0] caps[$];
    outs_t       snap;
    logic        r_dl;
    logic [7:0]  r_idx;

    initial begin
        vecs[0] = '{1'b1, 8'h01, 1'b0, 25'd0, 8'h00, 1'b1, '{1'b0, 15'd0, 8'h00, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b0, 1'b0}};
        vecs[1] = '{1'b1, 8'h01, 1'b1, 25'd0, 8'h11, 1'b1, '{1'b1, 15'd0, 8'h11, 1'b1, 1'b0, 16'd1, 16'h0011, 1'b0, 1'b0}};
        vecs[2] = '{1'b1, 8'h01, 1'b1, 25'd1, 8'h22, 1'b1, '{1'b1, 15'd1, 8'h22, 1'b1, 1'b0, 16'd2, 16'h0033, 1'b0, 1'b0}};
        vecs[3] = '{1'b1, 8'h01, 1'b1, 25'd2, 8'h33, 1'b1, '{1'b1, 15'd2, 8'h33, 1'b1, 1'b0, 16'd3, 16'h0066, 1'b0, 1'b0}};
        vecs[4] = '{1'b1, 8'h01, 1'b1, 25'd3, 8'h44, 1'b1, '{1'b1, 15'd3, 8'h44, 1'b1, 1'b0, 16'd4, 16'h00AA, 1'b0, 1'b0}};
        vecs[5] = '{1'b0, 8'h01, 1'b0, 25'd0, 8'h00, 1'b1, '{1'b0, 15'd0, 8'h00, 1'b1, 1'b0, 16'd4, 16'h00AA, 1'b0, 1'b0}};
        vecs[6] = '{1'b0, 8'h01, 1'b0, 25'd0, 8'h00, 1'b1, '{1'b0, 15'd0, 8'h00, 1'b0, 1'b1, 16'd4, 16'h00AA, 1'b0, 1'b0}};
        vecs[7] = '{1'b0, 8'h01, 1'b0, 25'd0, 8'h00, 1'b1, '{1'b0, 15'd0, 8'h00, 1'b0, 1'b1, 16'd4, 16'h00AA, 1'b0, 1'b0}};

        // Reset with a matching download already high: no load may start.
        dl      = 1'b1;
        idx     = 8'h01;
        ready   = 1'b1;
        reset_n = 1'b0;
        modelReset();
        #3;
        checkOutput("reset_outs", 64'(dutOuts()), 64'(0));
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'h01, 1'b1, 25'(k), 8'h05, 1'b1);
        checkOutput("no_start_hold", 64'(hold_reset), 64'(0));
        checkOutput("no_start_we", 64'(mem_we), 64'(0));
        applyStimulus(1'b0, 8'h01, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, 8'h01, 1'b0, '0, '0, 1'b1);

        // Basic four-byte load from the vector table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].dl, vecs[i].idx, vecs[i].wr, vecs[i].addr, vecs[i].dout, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), 64'(dutOuts()), 64'(vecs[i].exp));
        end

        // A foreign-index download must leave the resident image untouched.
        snap = vecs[7].exp;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'h02, 1'b1, 25'(k + 5), 8'h77, 1'b1);
            checkOutput("idx2_outs", 64'(dutOuts()), 64'(snap));
        end
        applyStimulus(1'b0, 8'h02, 1'b0, '0, '0, 1'b1);
        checkOutput("idx2_after", 64'(dutOuts()), 64'(snap));

        // Out-of-range byte: dropped, flagged, and the image is not valid.
        applyStimulus(1'b1, 8'h01, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 8'h01, 1'b1, 25'd32768, 8'h55, 1'b1);
        checkOutput("ovs_no_write", 64'(mem_we), 64'(0));
        checkOutput("ovs_flag", 64'(err_oversize), 64'(1));
        applyStimulus(1'b1, 8'h01, 1'b1, 25'd0, 8'h01, 1'b1);
        drainOut("ovs_drain");
        checkOutput("ovs_valid", 64'(cart_valid), 64'(0));
        checkOutput("ovs_size", 64'(cart_size), 64'(1));
        checkOutput("ovs_sum", 64'(checksum), 64'(16'h0001));

        // RAM stalled for 10 cycles while 6 bytes arrive back to back.
        applyStimulus(1'b1, 8'h01, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k < 6) applyStimulus(1'b1, 8'h01, 1'b1, 25'(16 + k), 8'(8'hA0 + k), 1'b0);
            else applyStimulus(1'b1, 8'h01, 1'b0, '0, '0, 1'b0);
            checkOutput("stall_head", 64'({mem_we, mem_addr, mem_data}), 64'({1'b1, 15'd16, 8'hA0}));
        end
        checkOutput("stall_overrun", 64'(err_overrun), 64'(1));
        caps.delete();
        for (int k = 0; k < 10; k++) begin
            if (mem_we) caps.push_back({mem_addr, mem_data});
            applyStimulus(1'b1, 8'h01, 1'b0, '0, '0, 1'b1);
        end
        checkOutput("stall_nwrites", 64'(caps.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("stall_write%0d", i), 64'((i < caps.size()) ? caps[i] : 23'd0),
                        64'({15'(16 + i), 8'(8'hA0 + i)}));
        drainOut("stall_drain");
        checkOutput("stall_valid", 64'(cart_valid), 64'(0));

        // Reset in the middle of a load with three bytes queued.
        applyStimulus(1'b1, 8'h01, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'h01, 1'b1, 25'(k), 8'(k + 1), 1'b0);
        checkOutput("midrst_pending", 64'(mem_we), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_outs", 64'(dutOuts()), 64'(0));
        modelReset();
        dl    = 1'b0;
        wr    = 1'b0;
        ready = 1'b1;
        @(posedge clk_sys);
        #1;
        checkOutput("midrst_held", 64'(dutOuts()), 64'(0));
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h01, 1'b0, '0, '0, 1'b1);
        checkOutput("midrst_after", 64'({mem_we, hold_reset}), 64'(0));

        // 256 bytes of FF: checksum wraps to FF00, size 256.
        applyStimulus(1'b1, 8'h01, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 256; k++) applyStimulus(1'b1, 8'h01, 1'b1, 25'(k), 8'hFF, 1'b1);
        drainOut("ff_drain");
        checkOutput("ff_sum", 64'(checksum), 64'(16'hFF00));
        checkOutput("ff_size", 64'(cart_size), 64'(256));
        checkOutput("ff_valid", 64'(cart_valid), 64'(1));

        // Random traffic; the index only changes while no download is active.
        r_dl  = 1'b0;
        r_idx = 8'h01;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                r_dl = ~r_dl;
                if (r_dl) r_idx = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h01;
            end
            applyStimulus(r_dl, r_idx, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 25'(32768 + $urandom_range(0, 100))
                                                      : 25'($urandom_range(0, 300)),
                          8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
